// File: rtl/dadda_adder_6.sv
// rtl/dadda_adder_6.sv - 6x6 signed Dadda-tree multiplier, low 6 bits registered; optional ovf via DADDA_ADDER6_OVF_EN
module dadda_adder_6 (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] A,
    input  logic [5:0] B,
`ifdef DADDA_ADDER6_OVF_EN
    output logic       ovf,
`endif
    output logic [5:0] C
);

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // pp[i][j] = a_i & b_j at weight i+j; sign-row/column cross terms inverted (Baugh-Wooley)
    logic [5:0] pp [6];
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                pp[i][j] = (A[i] & B[j]) ^ ((i == 5) != (j == 5));
            end
        end
    end

    // Stage 1: max column height 6 -> 4
    logic [5:0] s1, k1;
    assign {k1[0], s1[0]} = ha(pp[0][4], pp[1][3]);
    assign {k1[1], s1[1]} = fa(pp[0][5], pp[1][4], pp[2][3]);
    assign {k1[2], s1[2]} = ha(pp[3][2], pp[4][1]);
    assign {k1[3], s1[3]} = fa(pp[1][5], pp[2][4], pp[3][3]);
    assign {k1[4], s1[4]} = fa(pp[4][2], pp[5][1], 1'b1);
    assign {k1[5], s1[5]} = fa(pp[2][5], pp[3][4], pp[4][3]);

    // Stage 2: 4 -> 3
    logic [5:0] s2, k2;
    assign {k2[0], s2[0]} = ha(pp[0][3], pp[1][2]);
    assign {k2[1], s2[1]} = fa(s1[0], pp[2][2], pp[3][1]);
    assign {k2[2], s2[2]} = fa(pp[5][0], k1[0], s1[1]);
    assign {k2[3], s2[3]} = fa(k1[1], k1[2], s1[3]);
    assign {k2[4], s2[4]} = fa(pp[5][2], k1[3], k1[4]);
    assign {k2[5], s2[5]} = fa(pp[3][5], pp[4][4], pp[5][3]);

    // Stage 3: 3 -> 2
    logic [7:0] s3, k3;
    assign {k3[0], s3[0]} = ha(pp[0][2], pp[1][1]);
    assign {k3[1], s3[1]} = fa(s2[0], pp[2][1], pp[3][0]);
    assign {k3[2], s3[2]} = fa(pp[4][0], k2[0], s2[1]);
    assign {k3[3], s3[3]} = fa(s1[2], k2[1], s2[2]);
    assign {k3[4], s3[4]} = fa(s1[4], k2[2], s2[3]);
    assign {k3[5], s3[5]} = fa(s1[5], k2[3], s2[4]);
    assign {k3[6], s3[6]} = fa(k1[5], k2[4], s2[5]);
    assign {k3[7], s3[7]} = fa(pp[4][5], pp[5][4], k2[5]);

    // Two remaining rows; bit 11 of row_x is the weight-11 correction constant
    logic [11:0] row_x, row_y, prod;
    assign row_x = {1'b1, pp[5][5], k3[6:0], pp[2][0], pp[0][1], pp[0][0]};
    assign row_y = {1'b0, k3[7], s3[7:0], pp[1][0], 1'b0};

    always_comb begin
        logic carry;
        carry = 1'b0;
        for (int k = 0; k < 12; k++) begin
            {carry, prod[k]} = fa(row_x[k], row_y[k], carry);
        end
    end

`ifdef DADDA_ADDER6_OVF_EN
    logic ovf_d;
    assign ovf_d = !((&prod[11:5]) || !(|prod[11:5]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C   <= 6'b0;
            ovf <= 1'b0;
        end else begin
            C   <= prod[5:0];
            ovf <= ovf_d;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^prod[11:6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C <= 6'b0;
        end else begin
            C <= prod[5:0];
        end
    end
`endif

endmodule

// File: tb/tb_dadda_adder_6.sv
// tb/tb_dadda_adder_6.sv - scoreboard bench for dadda_adder_6 against a signed-multiply model
module tb_dadda_adder_6;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] A, B;
    logic [5:0] C;
`ifdef DADDA_ADDER6_OVF_EN
    logic       ovf;
`endif

    dadda_adder_6 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
`ifdef DADDA_ADDER6_OVF_EN
        .ovf (ovf),
`endif
        .C   (C)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] c;
        logic       ovf;
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    exp_t sb_q[$];
    logic issue_v = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: full integer product, wrap to 6 bits, range check
    task automatic drive(input logic [5:0] a, input logic [5:0] b);
        int   p;
        exp_t e;
        p = $signed(a) * $signed(b);
        e.c   = p[5:0];
        e.ovf = (p < -32) || (p > 31);
        e.a   = a;
        e.b   = b;
        A = a;
        B = b;
        issue_v = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        drive(a, b);
    endtask

    task automatic idle();
        @(negedge clk);
        issue_v = 1'b0;
    endtask

    always @(posedge clk) begin
        if (issue_v && !rst) begin
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (C !== e.c) begin
                    failures++;
                    $display("FAIL product A=%0d B=%0d: C got %b expected %b",
                             $signed(e.a), $signed(e.b), C, e.c);
                end
`ifdef DADDA_ADDER6_OVF_EN
                checks++;
                if (ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL ovf A=%0d B=%0d: got %b expected %b",
                             $signed(e.a), $signed(e.b), ovf, e.ovf);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] dir_a [9] = '{6'd0, 6'd3, 6'd16, 6'h38, 6'h30, 6'd15, 6'd14, 6'h20, 6'h20};
        logic [5:0] dir_b [9] = '{6'd0, 6'h3b, 6'd8, 6'h37, 6'h30, 6'd16, 6'h30, 6'h20, 6'd1};

        rst = 1'b1;
        A = 6'd31;
        B = 6'h21;
        #3;
        check("reset_async_C", int'(C), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold_C", int'(C), 0);
`ifdef DADDA_ADDER6_OVF_EN
            check("reset_hold_ovf", int'(ovf), 0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        drive(6'd31, 6'h21);

        for (int i = 0; i < 9; i++) issue(dir_a[i], dir_b[i]);

        // Async reset while holding a nonzero result
        issue(6'd15, 6'd16);
        idle();
        #2 rst = 1'b1;
        #1 check("async_reset_no_edge", int'(C), 0);
        @(posedge clk);
        #1 check("reset_over_edge", int'(C), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(6'h39, 6'd9);

        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                issue(6'(a), 6'(b));
            end
        end

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else issue(6'($urandom), 6'($urandom));
        end

        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dadda_adder_6.md
Name: dadda_adder_6

Overview:
- 6x6 signed (two's complement) multiplier built as a Dadda reduction tree, with a registered output.
- Product is truncated to 6 bits, with two's-complement wrap.
- Used as a small arithmetic leaf inside the high-speed datapath.
- Partial-product generation, Dadda reduction and the final carry-propagate adder are all structural in the combinational front end. One output register follows.

Parameters:
- None. Width is fixed at 6; the name encodes it.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  6  multiplicand, signed two's complement
- B  input  6  multiplier, signed two's complement
- C  output  6  registered low 6 bits of A*B, signed two's complement

Behaviour:
- Reset: while rst=1, C=6'b000000 immediately, independent of clk. Reset release is synchronous to the next clk edge.
- Latency: 1 cycle. C after rising edge k equals low6(A*B), using the A and B sampled at edge k.
- No handshake. Every cycle is a new operation, so throughput is 1 per clock.
- If rst asserts mid-operation, any in-flight result is discarded and C=0. The first valid C is the one after the first clk edge with rst=0.
- Internal product P is the full 12-bit signed product:
  - Partial products use Baugh-Wooley signed form: a_i&b_j, with the terms whose row/column index equals 5 (exactly one of i,j) inverted.
  - Constant correction bits are set at P weights 6 and 11.
- Dadda reduction:
  - Column heights reduce through the Dadda sequence 6 -> 4 -> 3 -> 2.
  - Each stage uses only the minimum number of full/half adders needed to meet the target height.
- Final stage: 12-bit ripple carry-propagate adder. The carry out of bit 11 is discarded.
- C = P[5:0]. Overflow wraps silently: results outside [-32,31] keep only the low 6 bits.
- Extreme values: -32*-32=1024 gives P=12'h400 and C=0. -32*1=-32 gives C=6'b100000.
- No behavioural '*' operator is allowed in the datapath. The bench may use '*' as its reference model.

Optional Feature:
- Macro: DADDA_ADDER6_OVF_EN
- When defined:
  - Adds output port ovf (1 bit), registered alongside C with the same reset value 0.
  - ovf=1 iff the full 12-bit product lies outside [-32,31], i.e. P[11:5] is not all-equal.
- When undefined:
  - Port ovf does not exist.
  - C behaviour is identical in both configurations.

Test Plan:
- rst=1 with A=31, B=-31 applied -> C=0 throughout the reset. After release, one clk later C=6'b111111 (-1, from -961); ovf=1.
- A=0, B=0 -> C=0, ovf=0. A=3, B=-5 -> C=6'b110001 (-15), ovf=0.
- Each pair below -> C as given, ovf=1:
  - A=16, B=8 -> C=0
  - A=-8, B=-9 -> C=8
  - A=-16, B=-16 -> C=0
- A=15, B=16 -> C=6'b110000 (-16), ovf=1. A=14, B=-16 -> C=6'b100000 (-32), ovf=1.
- New A/B every cycle for 4096 exhaustive pairs -> each C matches low6(A*B) of the previous cycle's inputs; ovf matches the range check.
- Assert rst asynchronously between clk edges while C≠0 -> C drops to 0 without a clock edge. Release rst -> the next edge loads the current product.
